// File: rtl/types_pkg.sv
// Shared RV64 integer-core types plus register-file / scoreboard constants.
package types_pkg;

    typedef logic [4:0]  reg_t;
    typedef logic [63:0] dword_t;

    localparam int   NUM_REGS = 32;
    localparam reg_t REG_ZERO = 5'd0;

    typedef logic [NUM_REGS-1:0] scoreboard_t;

endpackage

// File: rtl/register_file_if.sv
// Register-file access bus: decode/ID (tb side) drives addresses and write data,
// the register file (regs side) returns the two read operands.
interface registers_if;
    import types_pkg::*;

    reg_t   rs1;
    reg_t   rs2;
    reg_t   rd;
    dword_t wdata;
    logic   RegWrite;
    dword_t rdata1;
    dword_t rdata2;

    modport regs (
        input  rs1, rs2, rd, wdata, RegWrite,
        output rdata1, rdata2
    );

    modport tb (
        output rs1, rs2, rd, wdata, RegWrite,
        input  rdata1, rdata2
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, a running
// count of busy registers and the rs1/rs2 hazard lookup for issue logic.
module reg_scoreboard
    import types_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       wb_en,
    input  reg_t       wb_rd,
    input  logic       issue_valid,
    input  reg_t       issue_rd,
    input  logic       flush,
    input  reg_t       rs1,
    input  reg_t       rs2,
    output logic       busy1,
    output logic       busy2,
    output logic [5:0] pending_cnt
);

    logic [NUM_REGS-1:0] busy;
    logic                wb_ok;
    logic                issue_ok;
    logic                cnt_inc;
    logic                cnt_dec;

    // Count deltas: a clear that is immediately re-set by a new producer is net zero.
    always_comb begin
        wb_ok    = wb_en && (wb_rd != REG_ZERO);
        issue_ok = issue_valid && (issue_rd != REG_ZERO);
        cnt_inc  = issue_ok && !busy[issue_rd];
        cnt_dec  = wb_ok && busy[wb_rd] && !(issue_ok && (issue_rd == wb_rd));
    end

    // Busy vector and count: flush beats everything, then clear, then set.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else if (flush) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            if (wb_ok)
                busy[wb_rd] <= 1'b0;
            if (issue_ok)
                busy[issue_rd] <= 1'b1;
            pending_cnt <= pending_cnt + 6'(cnt_inc) - 6'(cnt_dec);
        end
    end

    // Hazard lookup from registered state only; x0 is never busy.
    always_comb begin
        busy1 = busy[rs1] && (rs1 != REG_ZERO);
        busy2 = busy[rs2] && (rs2 != REG_ZERO);
    end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit RV64 integer register file: two combinational read ports with
// optional write-to-read bypass, one synchronous write port, x0 tied to zero,
// and an integrated pending-write scoreboard.
module register_file
    import types_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int DATA_W    = 64,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       nRST,
    registers_if.regs  rf,
    input  logic       issue_valid,
    input  reg_t       issue_rd,
    input  logic       flush,
    output logic       busy1,
    output logic       busy2,
    output logic [5:0] pending_cnt
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = rf.RegWrite && (rf.rd != REG_ZERO);

    // Storage write; x0 is never written and reset clears every entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[rf.rd] <= rf.wdata;
        end
    end

    // Read muxing: x0 reads zero, otherwise array value or same-cycle write data.
    always_comb begin
        rf.rdata1 = '0;
        rf.rdata2 = '0;
        if (rf.rs1 != REG_ZERO)
            rf.rdata1 = (BYPASS_EN && wr_ok && (rf.rd == rf.rs1)) ? rf.wdata : regs[rf.rs1];
        if (rf.rs2 != REG_ZERO)
            rf.rdata2 = (BYPASS_EN && wr_ok && (rf.rd == rf.rs2)) ? rf.wdata : regs[rf.rs2];
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .CLK         (CLK),
        .nRST        (nRST),
        .wb_en       (rf.RegWrite),
        .wb_rd       (rf.rd),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .rs1         (rf.rs1),
        .rs2         (rf.rs2),
        .busy1       (busy1),
        .busy2       (busy2),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (bypassing and non-bypassing builds).
module tb_register_file;
    import types_pkg::*;

    logic       CLK;
    logic       nRST;
    logic       issue_valid;
    reg_t       issue_rd;
    logic       flush;
    logic       busy1, busy2;
    logic [5:0] pending_cnt;
    logic       nb_busy1, nb_busy2;
    logic [5:0] nb_pending_cnt;

    int checks;
    int passed;

    registers_if rf_if ();
    registers_if rf_nb ();

    assign rf_nb.rs1      = rf_if.rs1;
    assign rf_nb.rs2      = rf_if.rs2;
    assign rf_nb.rd       = rf_if.rd;
    assign rf_nb.wdata    = rf_if.wdata;
    assign rf_nb.RegWrite = rf_if.RegWrite;

    register_file #(.NUM_REGS(32), .DATA_W(64), .BYPASS_EN(1'b1)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .rf          (rf_if),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .busy1       (busy1),
        .busy2       (busy2),
        .pending_cnt (pending_cnt)
    );

    register_file #(.NUM_REGS(32), .DATA_W(64), .BYPASS_EN(1'b0)) dut_nb (
        .CLK         (CLK),
        .nRST        (nRST),
        .rf          (rf_nb),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .busy1       (nb_busy1),
        .busy2       (nb_busy2),
        .pending_cnt (nb_pending_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        rf_if.RegWrite = 1'b0;
        rf_if.rd       = '0;
        rf_if.wdata    = '0;
        issue_valid    = 1'b0;
        issue_rd       = '0;
        flush          = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        rf_if.rs1 = 5'd5;
        rf_if.rs2 = 5'd31;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++; if (rf_if.rdata1 !== 64'd0) $display("FAIL reset_rdata1 got %h exp 0", rf_if.rdata1); else passed++;
        checks++; if (rf_if.rdata2 !== 64'd0) $display("FAIL reset_rdata2 got %h exp 0", rf_if.rdata2); else passed++;
        checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got %b exp 0", busy1); else passed++;
        checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 got %b exp 0", busy2); else passed++;
        checks++; if (pending_cnt !== 6'd0) $display("FAIL reset_pending got %0d exp 0", pending_cnt); else passed++;
    endtask

    task automatic test_bypass();
        @(negedge CLK);
        rf_if.RegWrite = 1'b1;
        rf_if.rd       = 5'd3;
        rf_if.wdata    = 64'hDEAD_BEEF_0000_0001;
        rf_if.rs1      = 5'd3;
        rf_if.rs2      = 5'd3;
        #1;
        checks++; if (rf_if.rdata1 !== 64'hDEAD_BEEF_0000_0001) $display("FAIL bypass_rdata1 got %h exp deadbeef00000001", rf_if.rdata1); else passed++;
        checks++; if (rf_if.rdata2 !== 64'hDEAD_BEEF_0000_0001) $display("FAIL bypass_rdata2 got %h exp deadbeef00000001", rf_if.rdata2); else passed++;
        checks++; if (rf_nb.rdata1 !== 64'd0) $display("FAIL nobypass_old got %h exp 0", rf_nb.rdata1); else passed++;
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++; if (rf_if.rdata1 !== 64'hDEAD_BEEF_0000_0001) $display("FAIL bypass_held got %h exp deadbeef00000001", rf_if.rdata1); else passed++;
        checks++; if (rf_nb.rdata1 !== 64'hDEAD_BEEF_0000_0001) $display("FAIL nobypass_new got %h exp deadbeef00000001", rf_nb.rdata1); else passed++;
    endtask

    task automatic test_x0();
        @(negedge CLK);
        rf_if.RegWrite = 1'b1;
        rf_if.rd       = 5'd0;
        rf_if.wdata    = 64'hFFFF_FFFF_FFFF_FFFF;
        rf_if.rs1      = 5'd0;
        issue_valid    = 1'b1;
        issue_rd       = 5'd0;
        #1;
        checks++; if (rf_if.rdata1 !== 64'd0) $display("FAIL x0_same_cycle got %h exp 0", rf_if.rdata1); else passed++;
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++; if (rf_if.rdata1 !== 64'd0) $display("FAIL x0_next_cycle got %h exp 0", rf_if.rdata1); else passed++;
        checks++; if (pending_cnt !== 6'd0) $display("FAIL x0_issue_pending got %0d exp 0", pending_cnt); else passed++;
        checks++; if (busy1 !== 1'b0) $display("FAIL x0_busy1 got %b exp 0", busy1); else passed++;
    endtask

    task automatic test_issue_wb();
        @(negedge CLK);
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        rf_if.rs1   = 5'd7;
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++; if (busy1 !== 1'b1) $display("FAIL issue7_busy1 got %b exp 1", busy1); else passed++;
        checks++; if (pending_cnt !== 6'd1) $display("FAIL issue7_pending got %0d exp 1", pending_cnt); else passed++;
        @(negedge CLK);
        rf_if.RegWrite = 1'b1;
        rf_if.rd       = 5'd7;
        rf_if.wdata    = 64'h0123_4567_89AB_CDEF;
        issue_valid    = 1'b1;
        issue_rd       = 5'd7;
        #1;
        checks++; if (busy1 !== 1'b1) $display("FAIL wb7_busy_comb got %b exp 1", busy1); else passed++;
        checks++; if (rf_if.rdata1 !== 64'h0123_4567_89AB_CDEF) $display("FAIL wb7_bypass got %h exp 0123456789abcdef", rf_if.rdata1); else passed++;
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++; if (busy1 !== 1'b1) $display("FAIL setclr7_busy1 got %b exp 1", busy1); else passed++;
        checks++; if (pending_cnt !== 6'd1) $display("FAIL setclr7_pending got %0d exp 1", pending_cnt); else passed++;
        checks++; if (rf_if.rdata1 !== 64'h0123_4567_89AB_CDEF) $display("FAIL setclr7_data got %h exp 0123456789abcdef", rf_if.rdata1); else passed++;
        // plain writeback retires the producer
        rf_if.RegWrite = 1'b1;
        rf_if.rd       = 5'd7;
        rf_if.wdata    = 64'h0123_4567_89AB_CDEF;
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++; if (busy1 !== 1'b0) $display("FAIL wb7_cleared got %b exp 0", busy1); else passed++;
        checks++; if (pending_cnt !== 6'd0) $display("FAIL wb7_pending got %0d exp 0", pending_cnt); else passed++;
    endtask

    task automatic test_set_clear_diff();
        @(negedge CLK);
        issue_valid = 1'b1;
        issue_rd    = 5'd10;
        @(negedge CLK);
        rf_if.RegWrite = 1'b1;
        rf_if.rd       = 5'd10;
        rf_if.wdata    = 64'hAAAA_5555_AAAA_5555;
        issue_valid    = 1'b1;
        issue_rd       = 5'd11;
        rf_if.rs1      = 5'd10;
        rf_if.rs2      = 5'd11;
        #1;
        checks++; if (pending_cnt !== 6'd1) $display("FAIL diff_pending_before got %0d exp 1", pending_cnt); else passed++;
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++; if (busy1 !== 1'b0) $display("FAIL diff_busy10 got %b exp 0", busy1); else passed++;
        checks++; if (busy2 !== 1'b1) $display("FAIL diff_busy11 got %b exp 1", busy2); else passed++;
        checks++; if (pending_cnt !== 6'd1) $display("FAIL diff_pending got %0d exp 1", pending_cnt); else passed++;
        flush = 1'b1;
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++; if (pending_cnt !== 6'd0) $display("FAIL diff_flush_pending got %0d exp 0", pending_cnt); else passed++;
    endtask

    task automatic test_flush();
        for (int i = 4; i <= 6; i++) begin
            @(negedge CLK);
            issue_valid = 1'b1;
            issue_rd    = reg_t'(i);
        end
        @(negedge CLK);
        idle_inputs();
        rf_if.rs1 = 5'd5;
        rf_if.rs2 = 5'd9;
        #1;
        checks++; if (pending_cnt !== 6'd3) $display("FAIL three_issue_pending got %0d exp 3", pending_cnt); else passed++;
        checks++; if (busy1 !== 1'b1) $display("FAIL three_issue_busy5 got %b exp 1", busy1); else passed++;
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++; if (pending_cnt !== 6'd0) $display("FAIL flush_pending got %0d exp 0", pending_cnt); else passed++;
        checks++; if (busy1 !== 1'b0) $display("FAIL flush_busy5 got %b exp 0", busy1); else passed++;
        checks++; if (busy2 !== 1'b0) $display("FAIL flush_busy9 got %b exp 0", busy2); else passed++;
    endtask

    task automatic test_async_reset();
        logic [63:0] exp_v;
        for (int i = 1; i <= 31; i++) begin
            @(negedge CLK);
            rf_if.RegWrite = 1'b1;
            rf_if.rd       = reg_t'(i);
            rf_if.wdata    = 64'hC0DE_0000_0000_0000 | 64'(i);
            issue_valid    = 1'b1;
            issue_rd       = reg_t'(i);
        end
        @(negedge CLK);
        idle_inputs();
        rf_if.rs1 = 5'd1;
        rf_if.rs2 = 5'd31;
        #1;
        checks++; if (rf_if.rdata1 !== 64'hC0DE_0000_0000_0001) $display("FAIL fill_x1 got %h exp c0de000000000001", rf_if.rdata1); else passed++;
        checks++; if (rf_if.rdata2 !== 64'hC0DE_0000_0000_001F) $display("FAIL fill_x31 got %h exp c0de00000000001f", rf_if.rdata2); else passed++;
        checks++; if (pending_cnt !== 6'd31) $display("FAIL fill_pending got %0d exp 31", pending_cnt); else passed++;
        checks++; if (busy1 !== 1'b1) $display("FAIL fill_busy1 got %b exp 1", busy1); else passed++;
        #2;
        nRST = 1'b0;
        #1;
        checks++; if (rf_if.rdata1 !== 64'd0) $display("FAIL arst_rdata1 got %h exp 0", rf_if.rdata1); else passed++;
        checks++; if (rf_if.rdata2 !== 64'd0) $display("FAIL arst_rdata2 got %h exp 0", rf_if.rdata2); else passed++;
        checks++; if (pending_cnt !== 6'd0) $display("FAIL arst_pending got %0d exp 0", pending_cnt); else passed++;
        checks++; if (busy1 !== 1'b0) $display("FAIL arst_busy1 got %b exp 0", busy1); else passed++;
        @(negedge CLK);
        nRST = 1'b1;
        exp_v = 64'd0;
        for (int i = 1; i <= 31; i++) begin
            rf_if.rs1 = reg_t'(i);
            #1;
            checks++; if (rf_if.rdata1 !== exp_v) $display("FAIL post_reset_x%0d got %h exp 0", i, rf_if.rdata1); else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_bypass();
        test_x0();
        test_issue_wb();
        test_set_clear_diff();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
